// File: rtl/montgomery_mult_pipe.sv
// Three-stage pipelined Montgomery multiplier (REDC) with valid/ready handshake and tag sideband.
// Modes: MUL a*b, TO_MONT a*R^2, FROM_MONT a*1, SQR a*a; each result is the input product times R^-1 mod Q.
module montgomery_mult_pipe #(
  parameter int unsigned Q        = 3329,
  parameter int unsigned K        = 13,
  parameter int unsigned Q_PRIME  = 3327,
  parameter int unsigned R2_MOD_Q = 2882,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned TAG_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic              busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ((PROD_W > K + DATA_W) ? PROD_W : K + DATA_W) + 1;

  localparam logic [DATA_W-1:0] Q_DW      = DATA_W'(Q);
  localparam logic [DATA_W-1:0] R2_DW     = DATA_W'(R2_MOD_Q);
  localparam logic [DATA_W-1:0] ONE_DW    = DATA_W'(1);
  localparam logic [K-1:0]      Q_PRIME_K = K'(Q_PRIME);
  localparam logic [SUM_W-1:0]  Q_SUM     = SUM_W'(Q);

  typedef enum logic [1:0] {
    MODE_MUL       = 2'b00,
    MODE_TO_MONT   = 2'b01,
    MODE_FROM_MONT = 2'b10,
    MODE_SQR       = 2'b11
  } mode_e;

  logic advance;

  // Stage 1: operand select, full product, range check
  logic [DATA_W-1:0] b_sel;
  logic [PROD_W-1:0] t1_d, t1_q;
  logic              err1_d, err1_q;
  logic              v1_q;
  logic [TAG_W-1:0]  tag1_q;

  // Stage 2: m = T * Q' mod R
  logic [K-1:0]      m2_d, m2_q;
  logic [PROD_W-1:0] t2_q;
  logic              err2_q;
  logic              v2_q;
  logic [TAG_W-1:0]  tag2_q;

  // Stage 3: (T + m*Q) / R with one conditional subtract
  logic [SUM_W-1:0]  sum3;
  logic [SUM_W-1:0]  t3;
  logic [SUM_W-1:0]  red3;
  logic [DATA_W-1:0] res_d, res_q;
  logic              out_valid_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic              out_err_q;

  // The whole pipe moves in lockstep; only a stalled output freezes it.
  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  always_comb begin
    b_sel = in_b;
    unique case (mode_e'(in_mode))
      MODE_MUL:       b_sel = in_b;
      MODE_TO_MONT:   b_sel = R2_DW;
      MODE_FROM_MONT: b_sel = ONE_DW;
      MODE_SQR:       b_sel = in_a;
      default:        b_sel = in_b;
    endcase
    t1_d   = PROD_W'(in_a) * PROD_W'(b_sel);
    err1_d = (in_a >= Q_DW) | ((mode_e'(in_mode) == MODE_MUL) & (in_b >= Q_DW));
  end

  // Only the low K bits of T affect m, so the multiply is kept K bits wide.
  assign m2_d = t1_q[K-1:0] * Q_PRIME_K;

  always_comb begin
    sum3  = SUM_W'(t2_q) + SUM_W'(m2_q) * Q_SUM;
    t3    = sum3 >> K;
    red3  = (t3 >= Q_SUM) ? (t3 - Q_SUM) : t3;
    res_d = DATA_W'(red3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      t1_q        <= '0;
      err1_q      <= 1'b0;
      tag1_q      <= '0;
      v2_q        <= 1'b0;
      t2_q        <= '0;
      m2_q        <= '0;
      err2_q      <= 1'b0;
      tag2_q      <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else if (advance) begin
      v1_q        <= in_valid;
      t1_q        <= t1_d;
      err1_q      <= err1_d;
      tag1_q      <= in_tag;
      v2_q        <= v1_q;
      t2_q        <= t1_q;
      m2_q        <= m2_d;
      err2_q      <= err1_q;
      tag2_q      <= tag1_q;
      out_valid_q <= v2_q;
      res_q       <= res_d;
      out_tag_q   <= tag2_q;
      out_err_q   <= err2_q;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_tag    = out_tag_q;
  assign out_err    = out_err_q;
  assign busy       = v1_q | v2_q | out_valid_q;

endmodule

// File: tb/tb_montgomery_mult_pipe.sv
// Bench for montgomery_mult_pipe: directed vector table plus random traffic, checked through a
// FIFO scoreboard against an independent modular-arithmetic model.
module tb_montgomery_mult_pipe;

  localparam int unsigned DW = 12;
  localparam int unsigned TW = 4;
  localparam int          QM = 3329;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic          out_err;
  logic          busy;

  montgomery_mult_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int tag;
    bit err;
    bit chk;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    int         a;
    int         b;
    int         tag;
    int         res;
    bit         err;
  } vec_t;

  exp_t sbq[$];
  int   pop_cyc[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rnd_done;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int model(input logic [1:0] mode, input int a, input int b);
    longint bp;
    case (mode)
      2'd0:    bp = longint'(b);
      2'd1:    bp = 2882;
      2'd2:    bp = 1;
      default: bp = longint'(a);
    endcase
    return int'((longint'(a) * bp * 1352) % 3329);
  endfunction

  function automatic bit err_model(input logic [1:0] mode, input int a, input int b);
    return (a >= QM) || ((mode == 2'd0) && (b >= QM));
  endfunction

  // Output monitor: sampled mid-cycle, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!out_err) check("range", longint'(int'(out_result) < QM), 1);
      if (out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          pop_cyc.push_back(cyc);
          if (mon_e.chk) check("result", longint'(out_result), longint'(mon_e.res));
          check("tag", longint'(out_tag), longint'(mon_e.tag));
          check("err", longint'(out_err), longint'(mon_e.err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [1:0] mode, input int a, input int b, input int tag,
                      input int res, input bit err);
    int n;
    exp_t e;
    in_valid = 1'b1;
    in_mode  = mode;
    in_a     = DW'(a);
    in_b     = DW'(b);
    in_tag   = TW'(tag);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      e.res = res;
      e.tag = tag % 16;
      e.err = err;
      e.chk = !err;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    check("drain_pending", longint'(sbq.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t, required finish earlier", $time);
    $fatal(1, "global timeout");
  end

  vec_t vt[9];

  initial begin
    int lat, nv, held_res, held_tag;
    int a, b, m;

    vt[0] = '{2'd2, 1,    0,    5, 1352, 1'b0};
    vt[1] = '{2'd1, 1,    0,    6, 1534, 1'b0};
    vt[2] = '{2'd1, 0,    0,    7, 0,    1'b0};
    vt[3] = '{2'd0, 1534, 1534, 1, 1534, 1'b0};
    vt[4] = '{2'd0, 3328, 3328, 2, 1352, 1'b0};
    vt[5] = '{2'd3, 2,    0,    3, 2079, 1'b0};
    vt[6] = '{2'd0, 3329, 5,    9, 0,    1'b1};
    vt[7] = '{2'd0, 5,    3329, 10, 0,   1'b1};
    vt[8] = '{2'd3, 5,    4095, 11, 510, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'd0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    rnd_done  = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_result", longint'(out_result), 0);
    check("rst_out_tag", longint'(out_tag), 0);
    check("rst_out_err", longint'(out_err), 0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Conversions, each with latency measured in edges including the accepting one
    for (int i = 0; i < 3; i++) begin
      send(vt[i].mode, vt[i].a, vt[i].b, vt[i].tag, vt[i].res, vt[i].err);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check("latency", longint'(lat), 3);
      tick();
    end
    drain();

    // Back-to-back MUL/MUL/SQR with tags 1,2,3
    pop_cyc.delete();
    for (int i = 3; i < 6; i++)
      send(vt[i].mode, vt[i].a, vt[i].b, vt[i].tag, vt[i].res, vt[i].err);
    drain();
    check("b2b_count", longint'(pop_cyc.size()), 3);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap01", longint'(pop_cyc[1] - pop_cyc[0]), 1);
      check("b2b_gap12", longint'(pop_cyc[2] - pop_cyc[1]), 1);
    end

    // Error flag cases
    for (int i = 6; i < 9; i++)
      send(vt[i].mode, vt[i].a, vt[i].b, vt[i].tag, vt[i].res, vt[i].err);
    drain();

    // Backpressure: four transactions against a stalled consumer
    pop_cyc.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          a = int'($urandom_range(0, QM - 1));
          b = int'($urandom_range(0, QM - 1));
          send(2'd0, a, b, 8 + i, model(2'd0, a, b), 1'b0);
        end
      end
      begin
        nv = 0;
        @(negedge clk);
        while (!out_valid && nv < 50) begin
          @(negedge clk);
          nv++;
        end
        check("bp_valid_rise", longint'(out_valid), 1);
        check("bp_in_ready_low", longint'(in_ready), 0);
        held_res = int'(out_result);
        held_tag = int'(out_tag);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_hold_valid", longint'(out_valid), 1);
          check("bp_hold_result", longint'(out_result), longint'(held_res));
          check("bp_hold_tag", longint'(out_tag), longint'(held_tag));
          check("bp_hold_in_ready", longint'(in_ready), 0);
        end
        tick();
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", longint'(pop_cyc.size()), 4);

    // Reset with three transactions in flight
    send(2'd0, 7, 9, 1, model(2'd0, 7, 9), 1'b0);
    send(2'd3, 11, 0, 2, model(2'd3, 11, 0), 1'b0);
    send(2'd1, 13, 0, 3, model(2'd1, 13, 0), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    sbq.delete();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("midrst_no_stale", longint'(nv), 0);
    tick();

    // Random traffic against random backpressure
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          m = int'($urandom_range(0, 3));
          a = int'($urandom_range(0, QM - 1));
          b = int'($urandom_range(0, QM - 1));
          if ($urandom_range(0, 7) == 0) tick();
          send(2'(m), a, b, i % 16, model(2'(m), a, b), err_model(2'(m), a, b));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
